// File: rtl/idp_encoder_16.sv
// idp_encoder_16: 3C crosstalk-avoidance codec (11-bit data <-> 16-wire TSV codeword); optional IDP_PATTERN_CHECK_EN adds pattern_err
module idp_encoder_16 (
    input  logic        clock,
    input  logic        reset,
    input  logic [10:0] din,
    output logic [15:0] tsv,
    output logic [10:0] dout
`ifdef IDP_PATTERN_CHECK_EN
    ,
    output logic        pattern_err
`endif
);
    localparam logic [14:0][9:0] WT = {10'd987, 10'd610, 10'd377, 10'd233, 10'd144,
                                       10'd89,  10'd55,  10'd34,  10'd21,  10'd13,
                                       10'd8,   10'd5,   10'd3,   10'd2,   10'd1};
    logic [9:0]  v;
    logic [14:0] t;
    logic [15:0] c;
    logic [9:0]  sum;
    // greedy Zeckendorf split of din[9:0] into transitions, then integrate transitions from c[0]
    always_comb begin
        v = din[9:0];
        t = '0;
        for (int i = 14; i >= 0; i--) begin
            if (v >= WT[i]) begin
                t[i] = 1'b1;
                v = v - WT[i];
            end
        end
        c = '0;
        c[0] = din[10];
        for (int i = 0; i < 15; i++) c[i+1] = c[i] ^ t[i];
    end
    // codeword register; reset wins over the capture on the same edge
    always_ff @(posedge clock) tsv <= reset ? 16'h0000 : c;
    // weighted sum of wire transitions; 10-bit wrap matches truncating an 11-bit sum
    always_comb begin
        sum = '0;
        for (int i = 0; i < 15; i++) if (tsv[i] ^ tsv[i+1]) sum = sum + WT[i];
    end
    assign dout = {tsv[0], sum};
`ifdef IDP_PATTERN_CHECK_EN
    // two adjacent transitions is exactly a 010 or 101 window
    always_comb begin
        pattern_err = 1'b0;
        for (int j = 0; j < 14; j++)
            if ((tsv[j] ^ tsv[j+1]) && (tsv[j+1] ^ tsv[j+2])) pattern_err = 1'b1;
    end
`endif
endmodule

// File: tb/tb_idp_encoder_16.sv
// tb_idp_encoder_16: directed and random self-checking bench for idp_encoder_16
module tb_idp_encoder_16;
    logic        clock = 1'b0;
    logic        reset;
    logic [10:0] din;
    logic [15:0] tsv;
    logic [10:0] dout;
    int checks = 0;
    int errors = 0;
`ifdef IDP_PATTERN_CHECK_EN
    logic pattern_err;
`endif

    idp_encoder_16 dut (
        .clock(clock),
        .reset(reset),
        .din(din),
        .tsv(tsv),
        .dout(dout)
`ifdef IDP_PATTERN_CHECK_EN
        ,
        .pattern_err(pattern_err)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [10:0] d);
        din = d;
        @(posedge clock);
        #1;
    endtask

    function automatic logic has_3c_violation(input logic [15:0] w);
        logic bad = 1'b0;
        for (int j = 0; j < 14; j++) begin
            logic [2:0] win;
            win = {w[j+2], w[j+1], w[j]};
            if (win == 3'b010 || win == 3'b101) bad = 1'b1;
        end
        return bad;
    endfunction

    typedef struct { logic [10:0] d; logic [15:0] cw; } vec_t;
    vec_t vecs[$] = '{
        '{11'h000, 16'h0000}, '{11'h400, 16'hFFFF}, '{11'h001, 16'hFFFE},
        '{11'h3FF, 16'h80FC}, '{11'h002, 16'hFFFC}, '{11'h003, 16'hFFF8},
        '{11'h004, 16'h0006}, '{11'd987, 16'h8000}, '{11'h401, 16'h0001},
        '{11'h7FF, 16'h7F03}
    };

    initial begin
        logic [10:0] d;
        reset = 1'b1;
        din = 11'h5A5;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("reset_tsv", 32'(tsv), 32'h0000);
        chk("reset_dout", 32'(dout), 32'h000);
`ifdef IDP_PATTERN_CHECK_EN
        chk("reset_perr", 32'(pattern_err), 32'h0);
`endif
        reset = 1'b0;
        foreach (vecs[k]) begin
            step(vecs[k].d);
            chk($sformatf("enc_%h", vecs[k].d), 32'(tsv), 32'(vecs[k].cw));
            chk($sformatf("dec_%h", vecs[k].d), 32'(dout), 32'(vecs[k].d));
        end
        din = 11'h001;
        #1;
        chk("latency_hold", 32'(tsv), 32'h7F03);
        @(posedge clock); #1;
        chk("latency_load", 32'(tsv), 32'hFFFE);
        reset = 1'b1;
        step(11'h3FF);
        chk("midreset_tsv", 32'(tsv), 32'h0000);
        chk("midreset_dout", 32'(dout), 32'h000);
        reset = 1'b0;
        step(11'h3FF);
        chk("postreset_tsv", 32'(tsv), 32'h80FC);
        for (int n = 0; n < 2000; n++) begin
            d = 11'($urandom_range(0, 2047));
            step(d);
            chk("rand_roundtrip", 32'(dout), 32'(d));
            chk("rand_3c", 32'(has_3c_violation(tsv)), 32'h0);
`ifdef IDP_PATTERN_CHECK_EN
            chk("rand_perr", 32'(pattern_err), 32'h0);
`endif
        end
        @(negedge clock);
        force dut.tsv = 16'h0002;
        #1;
        chk("illegal_dout", 32'(dout), 32'h003);
`ifdef IDP_PATTERN_CHECK_EN
        chk("illegal_perr", 32'(pattern_err), 32'h1);
`endif
        release dut.tsv;
        step(11'h000);
        chk("recover_tsv", 32'(tsv), 32'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
